flow_rate_counter: RTL and testbench

Measures a flow sensor's pulse train and produces the 6-bit flow rate, in litres per minute, that feeds the flow-condition logic. It is the producer end of the `flow_rate` bus.
- Counts debounced rising edges of the sensor pulse over a fixed gate window.
- Divides the count by a pulses-per-unit prescaler and saturates the result at 63.
- Publishes each result with a one-cycle valid strobe.

---
 rtl/flow_pkg.sv | 26 ++
 rtl/flow_pulse_sync.sv | 67 ++++++
 rtl/flow_rate_counter.sv | 104 ++++++++++
 tb/tb_flow_rate_counter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// Shared constants, FSM state type and clamp helper for the flow-rate block.
// Build option: define FLOW_GLITCH_FILTER_EN to add the input stability filter.
package flow_pkg;

  localparam int FLOW_W   = 6;
  localparam int FLOW_MAX = 63;
  localparam int UNIT_W   = 7;

  localparam logic [UNIT_W-1:0] UNIT_MAX = 7'd63;
  localparam logic [UNIT_W-1:0] UNIT_SAT = 7'd64;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } flow_state_t;

  function automatic logic [FLOW_W-1:0] clamp_units(
    input logic [UNIT_W-1:0] units
  );
    if (units > UNIT_MAX) begin
      return FLOW_W'(FLOW_MAX);
    end
    return units[FLOW_W-1:0];
  endfunction

endpackage

// File: rtl/flow_pulse_sync.sv
// Sensor pulse conditioning: 2-flop synchronizer, optional stability filter
// (FLOW_GLITCH_FILTER_EN) and registered rising-edge detector.
module flow_pulse_sync (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic edge_pulse
);

  logic sync_a;
  logic sync_b;

  // Two-stage synchronizer for the asynchronous sensor input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= pulse_in;
      sync_b <= sync_a;
    end
  end

`ifdef FLOW_GLITCH_FILTER_EN
  logic hist_a;
  logic hist_b;
  logic level;
  logic all_hi;
  logic all_lo;

  assign all_hi = sync_b & hist_a & hist_b;
  assign all_lo = ~(sync_b | hist_a | hist_b);

  // Level follows the input only after 3 equal samples; rise gives the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_a     <= 1'b0;
      hist_b     <= 1'b0;
      level      <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      hist_a     <= sync_b;
      hist_b     <= hist_a;
      edge_pulse <= all_hi & ~level;
      if (all_hi) begin
        level <= 1'b1;
      end else if (all_lo) begin
        level <= 1'b0;
      end
    end
  end
`else
  logic prev;

  // Rising edge of the synced level, registered to a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      prev       <= sync_b;
      edge_pulse <= sync_b & ~prev;
    end
  end
`endif

endmodule

// File: rtl/flow_rate_counter.sv
// Gated pulse counter producing a saturating 6-bit L/min flow rate.
// Build option: FLOW_GLITCH_FILTER_EN enables the input stability filter.
module flow_rate_counter
  import flow_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int PULSE_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pulse_in,
  output logic [FLOW_W-1:0] flow_rate,
  output logic              flow_valid,
  output logic              saturated
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int PW = $clog2(PULSE_DIV + 1);

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [PW-1:0] DIV_LAST  = PW'(PULSE_DIV - 1);

  flow_state_t state;
  flow_state_t next_state;

  logic              edge_pulse;
  logic [GW-1:0]     gate;
  logic [PW-1:0]     pre;
  logic [UNIT_W-1:0] units;
  logic [UNIT_W-1:0] units_nx;
  logic              run;
  logic              window_end;
  logic              pre_wrap;

  flow_pulse_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .edge_pulse (edge_pulse)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: enable starts a run, any low sample aborts it.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (enable)  next_state = MEASURE;
      MEASURE: if (!enable) next_state = IDLE;
    endcase
  end

  // Run qualifier, window end and the unit count including this cycle's edge.
  always_comb begin
    run        = (state == MEASURE) && enable;
    window_end = run && (gate == GATE_LAST);
    pre_wrap   = edge_pulse && (pre == DIV_LAST);
    units_nx   = units;
    if (pre_wrap && (units != UNIT_SAT)) begin
      units_nx = units + 7'd1;
    end
  end

  // Gate, prescaler and unit counters; cleared outside a run and per window.
  always_ff @(posedge clk) begin
    if (rst || !run || window_end) begin
      gate  <= '0;
      pre   <= '0;
      units <= '0;
    end else begin
      gate  <= gate + 1'b1;
      units <= units_nx;
      if (pre_wrap) begin
        pre <= '0;
      end else if (edge_pulse) begin
        pre <= pre + 1'b1;
      end
    end
  end

  // Publish the finished window with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      flow_rate  <= '0;
      saturated  <= 1'b0;
      flow_valid <= 1'b0;
    end else begin
      flow_valid <= window_end;
      if (window_end) begin
        flow_rate <= clamp_units(units_nx);
        saturated <= (units_nx > UNIT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_flow_rate_counter.sv
// Self-checking bench: three flow_rate_counter configurations on shared
// stimulus, a window-level reference model and directed literal checks.
module tb_flow_rate_counter;

`ifdef FLOW_GLITCH_FILTER_EN
  localparam bit F      = 1'b1;
`else
  localparam bit F      = 1'b0;
`endif
  localparam int GA     = 100;
  localparam int GB     = F ? 600 : 400;
  localparam int GC     = F ? 200 : 100;
  localparam int HI_MIN = F ? 4 : 2;
  localparam int LO     = F ? 4 : 2;
  localparam int HB     = F ? 4 : 3;
  localparam int LAT    = F ? 5 : 3;
  localparam int N1     = F ? 12 : 17;
  localparam int EXP6   = F ? 3 : 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       pulse_in;
  logic [5:0] d_rate  [3];
  logic       d_valid [3];
  logic       d_sat   [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int mg [3] = '{GA, GB, GC};
  int md [3] = '{1, 1, 4};

  flow_rate_counter #(.GATE_CYCLES(GA), .PULSE_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
    .flow_rate(d_rate[0]), .flow_valid(d_valid[0]), .saturated(d_sat[0])
  );

  flow_rate_counter #(.GATE_CYCLES(GB), .PULSE_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
    .flow_rate(d_rate[1]), .flow_valid(d_valid[1]), .saturated(d_sat[1])
  );

  flow_rate_counter #(.GATE_CYCLES(GC), .PULSE_DIV(4)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
    .flow_rate(d_rate[2]), .flow_valid(d_valid[2]), .saturated(d_sat[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  // Reference model: sampled pulse history -> counted edges 3 cycles later,
  // per-window raw edge count, result = min(count / div, 63).
  bit       m_live = 0;
  bit       ph1, ph2, mlvl, dl0, dl1, dl2;
  bit       m_meas  [3];
  int       m_gate  [3];
  int       m_cnt   [3];
  int       m_rate  [3];
  bit       m_sat   [3];
  bit       m_valid [3];

  always @(posedge clk) begin
    bit p;
    bit rise;
    bit e_now;
    int u;
    e_now = dl2;
    if (rst) begin
      {ph1, ph2, mlvl, dl0, dl1, dl2} = '0;
      for (int i = 0; i < 3; i++) begin
        m_meas[i] = 0; m_gate[i] = 0; m_cnt[i] = 0;
        m_rate[i] = 0; m_sat[i] = 0; m_valid[i] = 0;
      end
    end else begin
      p = pulse_in;
      if (F) begin
        rise = 0;
        if (p == ph1 && p == ph2 && p != mlvl) begin
          mlvl = p;
          rise = p;
        end
      end else begin
        rise = p & ~ph1;
      end
      ph2 = ph1; ph1 = p;
      dl2 = dl1; dl1 = dl0; dl0 = rise;
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0;
        if (!m_meas[i]) begin
          m_gate[i] = 0;
          m_cnt[i]  = 0;
          if (enable) m_meas[i] = 1;
        end else if (!enable) begin
          m_meas[i] = 0;
        end else begin
          if (e_now) m_cnt[i]++;
          if (m_gate[i] == mg[i] - 1) begin
            u = m_cnt[i] / md[i];
            m_rate[i]  = (u > 63) ? 63 : u;
            m_sat[i]   = (u > 63);
            m_valid[i] = 1;
            m_cnt[i]   = 0;
            m_gate[i]  = 0;
          end else begin
            m_gate[i]++;
          end
        end
      end
    end
    m_live = 1;
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_rate%0d@%0d", i, cyc), d_rate[i], m_rate[i]);
        chk($sformatf("model_valid%0d@%0d", i, cyc), d_valid[i], m_valid[i]);
        chk($sformatf("model_sat%0d@%0d", i, cyc), d_sat[i], m_sat[i]);
      end
    end
  end

  task automatic do_reset();
    rst = 1; enable = 0; pulse_in = 0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      pulse_in = 1;
      repeat (hi) @(negedge clk);
      pulse_in = 0;
      if (k != n - 1) repeat (lo) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int inst, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_valid[inst] && n < limit);
    chk($sformatf("valid_timeout%0d", inst), d_valid[inst], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_en;
    int vcount;
    int held_bad;

    do_reset();
    @(negedge clk);
    chk("reset_rate", d_rate[0], 0);
    chk("reset_valid", d_valid[0], 0);
    chk("reset_sat", d_sat[0], 0);

    // Clean pulses in the first window, then an empty window.
    enable = 1;
    t_en = cyc;
    pulses(N1, 4, LO);
    wait_valid(0, 150);
    chk("t1_latency", cyc - t_en, GA + 1);
    chk("t1_rate", d_rate[0], N1);
    chk("t1_sat", d_sat[0], 0);
    wait_valid(0, 150);
    chk("t1_empty_rate", d_rate[0], 0);

    // Aborted window: no strobe, output held, next window counts afresh.
    do_reset();
    enable = 1;
    pulses(N1, 4, LO);
    wait_valid(0, 150);
    chk("t4_first_rate", d_rate[0], N1);
    pulses(8, 4, LO);
    repeat (2) @(negedge clk);
    enable = 0;
    vcount = 0;
    held_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_valid[0]) vcount++;
      if (d_rate[0] != 6'(N1)) held_bad++;
    end
    chk("t4_abort_valids", vcount, 0);
    chk("t4_held_changes", held_bad, 0);
    enable = 1;
    pulses(3, 4, LO);
    wait_valid(0, 150);
    chk("t4_rate", d_rate[0], 3);

    // Saturation on the long-gate instance, then recovery.
    do_reset();
    enable = 1;
    pulses(70, HB, LO);
    wait_valid(1, GB + 50);
    chk("t2_sat_rate", d_rate[1], 63);
    chk("t2_sat_flag", d_sat[1], 1);
    pulses(5, 4, LO);
    wait_valid(1, GB + 50);
    chk("t2_rate", d_rate[1], 5);
    chk("t2_sat_clear", d_sat[1], 0);

    // Prescaler 4: 23 pulses give 5, remainder does not carry.
    do_reset();
    enable = 1;
    pulses(23, HI_MIN, LO);
    wait_valid(2, GC + 50);
    chk("t3_rate_a", d_rate[2], 5);
    pulses(23, HI_MIN, LO);
    wait_valid(2, GC + 50);
    chk("t3_rate_b", d_rate[2], 5);

    // Edge landing exactly on the last gate cycle.
    do_reset();
    enable = 1;
    repeat (GA - LAT) @(negedge clk);
    pulses(1, HI_MIN, LO);
    wait_valid(0, 150);
    chk("t5_last_cycle_rate", d_rate[0], 1);

    // Reset mid-window clears outputs and produces no strobe.
    pulses(3, 4, LO);
    repeat (40) @(negedge clk);
    rst = 1;
    enable = 0;
    @(negedge clk);
    rst = 0;
    chk("t5_rst_rate", d_rate[0], 0);
    chk("t5_rst_sat", d_sat[0], 0);
    chk("t5_rst_valid", d_valid[0], 0);
    vcount = 0;
    repeat (150) begin
      @(negedge clk);
      if (d_valid[0]) vcount++;
    end
    chk("t5_no_valid", vcount, 0);

    // Glitch rejection (filter) or short pulses accepted (no filter).
    do_reset();
    enable = 1;
    if (F) begin
      pulses(1, 1, 0);
      repeat (5) @(negedge clk);
      pulses(1, 2, 0);
      repeat (5) @(negedge clk);
      pulses(3, 4, 4);
    end else begin
      pulses(4, 2, 2);
    end
    wait_valid(0, 150);
    chk("t6_rate", d_rate[0], EXP6);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
